mux2_rr_arbiter: RTL and testbench

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter driving a shared data mux.
// Optional burst limit enabled by macro MUX2_ARB_BURST_LIMIT_EN (uses MAX_BEATS).
`default_nettype none

module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_i,
  input  logic [1:0]         last_i,
  input  logic [2*WIDTH-1:0] data_i,
  input  logic               ready_i,
  output logic [1:0]         gnt_o,
  output logic               select_n,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   prio_q, prio_d;
  logic   w_own;
  logic   w_other;
  logic   w_own_req;
  logic   w_beat;
  logic   w_release;

  // An out-of-range MAX_BEATS leaves the counter compare unreachable or degenerate.
  if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_max_beats_out_of_range
  end

`ifdef MUX2_ARB_BURST_LIMIT_EN
  localparam logic [7:0] BEAT_LAST = 8'(MAX_BEATS - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign w_own     = (state_q == OWN1);
  assign w_other   = ~w_own;
  assign w_own_req = req_i[w_own];
  assign w_beat    = (state_q != IDLE) && w_own_req && ready_i;
  assign w_release = (state_q != IDLE) && (!w_own_req || (w_beat && last_i[w_own]));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
`ifdef MUX2_ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    if (state_q == IDLE) begin
      if (req_i[0] && req_i[1]) begin
        state_d = prio_q ? OWN1 : OWN0;
        sel_d   = prio_q;
      end else if (req_i[0]) begin
        state_d = OWN0;
        sel_d   = 1'b0;
      end else if (req_i[1]) begin
        state_d = OWN1;
        sel_d   = 1'b1;
      end
    end else if (w_release) begin
      prio_d = w_other;
      if (req_i[w_other]) begin
        state_d = w_other ? OWN1 : OWN0;
        sel_d   = w_other;
      end else begin
        state_d = IDLE;
      end
    end
`ifdef MUX2_ARB_BURST_LIMIT_EN
    else if (w_beat) begin
      if (cnt_q == BEAT_LAST) begin
        // Limit reached: hand over only if the other side is waiting.
        cnt_d = 8'd0;
        if (req_i[w_other]) begin
          state_d = w_other ? OWN1 : OWN0;
          sel_d   = w_other;
          prio_d  = w_own;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

`ifdef MUX2_ARB_BURST_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign gnt_o    = {state_q == OWN1, state_q == OWN0};
  assign select_n = sel_q;
  assign data_o   = sel_q ? data_i[2*WIDTH-1:WIDTH] : data_i[WIDTH-1:0];
  assign valid_o  = |(gnt_o & req_i);
  assign busy_o   = |gnt_o;

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter (default WIDTH=8, MAX_BEATS=4).
`default_nettype none

module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
`ifdef MUX2_ARB_BURST_LIMIT_EN
  localparam int  LIM   = 4;
  localparam bit  BURST = 1'b1;
`else
  localparam int  LIM   = 10;
  localparam bit  BURST = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic [1:0]         req_i;
  logic [1:0]         last_i;
  logic [2*WIDTH-1:0] data_i;
  logic               ready_i;
  logic [1:0]         gnt_o;
  logic               select_n;
  logic [WIDTH-1:0]   data_o;
  logic               valid_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .last_i   (last_i),
    .data_i   (data_i),
    .ready_i  (ready_i),
    .gnt_o    (gnt_o),
    .select_n (select_n),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_i   = 2'b00;
    last_i  = 2'b00;
    ready_i = 1'b1;
    data_i  = {8'h5A, 8'hA5};
    #3;
    check("rst_gnt", 16'(gnt_o), 16'h0);
    check("rst_sel", 16'(select_n), 16'h0);
    check("rst_busy", 16'(busy_o), 16'h0);
    check("rst_valid", 16'(valid_o), 16'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester, three beats of 0xA5, last on the third.
    req_i = 2'b01;
    tick();
    check("single_gnt1", 16'(gnt_o), 16'h1);
    check("single_valid1", 16'(valid_o), 16'h1);
    check("single_data1", 16'(data_o), 16'hA5);
    tick();
    check("single_gnt2", 16'(gnt_o), 16'h1);
    check("single_data2", 16'(data_o), 16'hA5);
    tick();
    last_i = 2'b01;
    check("single_gnt3", 16'(gnt_o), 16'h1);
    check("single_data3", 16'(data_o), 16'hA5);
    tick();
    check("single_idle_gnt", 16'(gnt_o), 16'h0);
    check("single_idle_busy", 16'(busy_o), 16'h0);
    req_i  = 2'b00;
    last_i = 2'b00;
    tick();
    check("single_stay_idle", 16'(gnt_o), 16'h0);

    // Contention from reset, then single-beat fairness.
    rst_n = 1'b0;
    #1;
    rst_n  = 1'b1;
    req_i  = 2'b11;
    last_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fair_gnt%0d", i), 16'(gnt_o), (i % 2 == 0) ? 16'h1 : 16'h2);
      check($sformatf("fair_sel%0d", i), 16'(select_n), (i % 2 == 0) ? 16'h0 : 16'h1);
      check($sformatf("fair_data%0d", i), 16'(data_o), (i % 2 == 0) ? 16'hA5 : 16'h5A);
    end

    // Owner 1 stalled with last asserted, then aborts.
    req_i   = 2'b10;
    ready_i = 1'b0;
    last_i  = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("stall_gnt%0d", i), 16'(gnt_o), 16'h2);
      check($sformatf("stall_valid%0d", i), 16'(valid_o), 16'h1);
    end
    req_i = 2'b00;
    tick();
    check("abort_gnt", 16'(gnt_o), 16'h0);
    check("abort_sel_hold", 16'(select_n), 16'h1);
    check("abort_valid", 16'(valid_o), 16'h0);

    // Asynchronous reset while requester 1 owns the bus.
    ready_i = 1'b1;
    last_i  = 2'b00;
    req_i   = 2'b10;
    tick();
    check("pre_rst_gnt", 16'(gnt_o), 16'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 16'(gnt_o), 16'h0);
    check("async_rst_sel", 16'(select_n), 16'h0);
    check("async_rst_valid", 16'(valid_o), 16'h0);
    check("async_rst_busy", 16'(busy_o), 16'h0);
    #1;
    rst_n = 1'b1;

    // Ten-beat burst from requester 0 with requester 1 waiting.
    req_i  = 2'b11;
    last_i = 2'b00;
    for (int i = 1; i <= LIM + 1; i++) begin
      tick();
      if (i == LIM && !BURST) last_i = 2'b01;
      check($sformatf("burst_gnt%0d", i), 16'(gnt_o), (i <= LIM) ? 16'h1 : 16'h2);
      check($sformatf("burst_sel%0d", i), 16'(select_n), (i <= LIM) ? 16'h0 : 16'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
